// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard controller with per-cause stall counters
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decode_i_rs1,
    input  logic [4:0]       decode_i_rs2,
    input  logic             decode_i_rs1_used,
    input  logic             decode_i_rs2_used,
    input  logic [4:0]       regE_i_rd,
    input  logic             regE_i_reg_wen,
    input  logic             regE_i_is_load,
    input  logic             execute_i_redirect,
    input  logic             execute_i_mdu_busy,
    input  logic             memory_i_dcache_req,
    input  logic             memory_i_dcache_ready,
    input  logic             ctrl_i_cnt_clr,
    output logic             ctrl_o_stall_F,
    output logic             ctrl_o_stall_D,
    output logic             ctrl_o_stall_E,
    output logic             ctrl_o_stall_M,
    output logic             ctrl_o_bubble_D,
    output logic             ctrl_o_bubble_E,
    output logic             ctrl_o_bubble_M,
    output logic             ctrl_o_bubble_W,
    output logic [1:0]       ctrl_o_state,
    output logic [CNT_W-1:0] ctrl_o_cnt_mem,
    output logic [CNT_W-1:0] ctrl_o_cnt_ex,
    output logic [CNT_W-1:0] ctrl_o_cnt_lu,
    output logic [CNT_W-1:0] ctrl_o_cnt_flush
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOADUSE  = 2'd1,
        ST_EX_WAIT  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;
    logic   memstall, lu;
    logic   inc_mem, inc_ex, inc_lu, inc_flush;

    logic [CNT_W-1:0] cnt_mem_q, cnt_ex_q, cnt_lu_q, cnt_flush_q;

    assign memstall = memory_i_dcache_req & ~memory_i_dcache_ready;

    // Writes to x0 are discarded, so they never create a load-use dependency.
    assign lu = regE_i_is_load & regE_i_reg_wen & (regE_i_rd != 5'd0) &
                ((decode_i_rs1_used & (decode_i_rs1 == regE_i_rd)) |
                 (decode_i_rs2_used & (decode_i_rs2 == regE_i_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Held stages keep a pending redirect in E alive, so it is serviced once the stall clears.
    always_comb begin
        state_d         = ST_RUN;
        ctrl_o_stall_F  = 1'b0;
        ctrl_o_stall_D  = 1'b0;
        ctrl_o_stall_E  = 1'b0;
        ctrl_o_stall_M  = 1'b0;
        ctrl_o_bubble_D = 1'b0;
        ctrl_o_bubble_E = 1'b0;
        ctrl_o_bubble_M = 1'b0;
        ctrl_o_bubble_W = 1'b0;
        inc_mem         = 1'b0;
        inc_ex          = 1'b0;
        inc_lu          = 1'b0;
        inc_flush       = 1'b0;
        if (!rst) begin
            state_d = ST_RUN;
        end else if (memstall) begin
            ctrl_o_stall_F  = 1'b1;
            ctrl_o_stall_D  = 1'b1;
            ctrl_o_stall_E  = 1'b1;
            ctrl_o_stall_M  = 1'b1;
            ctrl_o_bubble_W = 1'b1;
            inc_mem         = 1'b1;
            state_d         = ST_MEM_WAIT;
        end else if (execute_i_mdu_busy) begin
            ctrl_o_stall_F  = 1'b1;
            ctrl_o_stall_D  = 1'b1;
            ctrl_o_stall_E  = 1'b1;
            ctrl_o_bubble_M = 1'b1;
            inc_ex          = 1'b1;
            state_d         = ST_EX_WAIT;
        end else if (execute_i_redirect) begin
            ctrl_o_bubble_D = 1'b1;
            ctrl_o_bubble_E = 1'b1;
            inc_flush       = 1'b1;
            state_d         = ST_RUN;
        end else if (lu) begin
            ctrl_o_stall_F  = 1'b1;
            ctrl_o_stall_D  = 1'b1;
            ctrl_o_bubble_E = 1'b1;
            inc_lu          = 1'b1;
            state_d         = ST_LOADUSE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_mem_q   <= '0;
            cnt_ex_q    <= '0;
            cnt_lu_q    <= '0;
            cnt_flush_q <= '0;
        end else if (ctrl_i_cnt_clr) begin
            cnt_mem_q   <= '0;
            cnt_ex_q    <= '0;
            cnt_lu_q    <= '0;
            cnt_flush_q <= '0;
        end else begin
            if (inc_mem && cnt_mem_q != CNT_MAX) begin
                cnt_mem_q <= cnt_mem_q + CNT_ONE;
            end
            if (inc_ex && cnt_ex_q != CNT_MAX) begin
                cnt_ex_q <= cnt_ex_q + CNT_ONE;
            end
            if (inc_lu && cnt_lu_q != CNT_MAX) begin
                cnt_lu_q <= cnt_lu_q + CNT_ONE;
            end
            if (inc_flush && cnt_flush_q != CNT_MAX) begin
                cnt_flush_q <= cnt_flush_q + CNT_ONE;
            end
        end
    end

    assign ctrl_o_state     = state_q;
    assign ctrl_o_cnt_mem   = cnt_mem_q;
    assign ctrl_o_cnt_ex    = cnt_ex_q;
    assign ctrl_o_cnt_lu    = cnt_lu_q;
    assign ctrl_o_cnt_flush = cnt_flush_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of each stall-cause counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports decode_i_rs1, decode_i_rs2  input  5 each  source register indices of the instruction in D.
REQ-005 SHALL have ports decode_i_rs1_used, decode_i_rs2_used  input  1 each  source actually read.
REQ-006 SHALL have ports regE_i_rd  input  5, regE_i_reg_wen  input  1, regE_i_is_load  input  1  destination info of the instruction in E.
REQ-007 SHALL have port execute_i_redirect  input  1  branch/jump taken in E; PC redirect this cycle.
REQ-008 SHALL have port execute_i_mdu_busy  input  1  multi-cycle mul/div in E not finished (level).
REQ-009 SHALL have ports memory_i_dcache_req, memory_i_dcache_ready  input  1 each  load/store in M, data cache response.
REQ-010 SHALL have port ctrl_i_cnt_clr  input  1  synchronous clear of all counters.
REQ-011 SHALL have ports ctrl_o_stall_F, ctrl_o_stall_D, ctrl_o_stall_E, ctrl_o_stall_M  output  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
REQ-012 SHALL have ports ctrl_o_bubble_D, ctrl_o_bubble_E, ctrl_o_bubble_M, ctrl_o_bubble_W  output  1 each  load a NOP (reg_wen=0) into IF-ID / ID-EX / EX-MEM / MEM-WB register.
REQ-013 SHALL have port ctrl_o_state  output  2  registered cause of previous cycle: 0 RUN, 1 LOADUSE, 2 EX_WAIT, 3 MEM_WAIT.
REQ-014 SHALL have ports ctrl_o_cnt_mem, ctrl_o_cnt_ex, ctrl_o_cnt_lu, ctrl_o_cnt_flush  output  CNT_W each  per-cause cycle counters.

Function
REQ-015 SHALL compute memstall = memory_i_dcache_req & !memory_i_dcache_ready.
REQ-016 SHALL compute lu = regE_i_is_load & regE_i_reg_wen & (regE_i_rd != 0) & ((rs1_used & rs1 == rd) | (rs2_used & rs2 == rd)); rd = x0 never hazards.
REQ-017 SHALL select exactly one cause per cycle, priority: memstall > mdu_busy > redirect > lu > none.
REQ-018 memstall: stall_F/D/E/M = 1, bubble_W = 1, all else 0; next state MEM_WAIT.
REQ-019 mdu_busy: stall_F/D/E = 1, bubble_M = 1, all else 0; next state EX_WAIT.
REQ-020 redirect: bubble_D = 1, bubble_E = 1, no stalls; next state RUN; concurrent lu ignored.
REQ-021 lu: stall_F/D = 1, bubble_E = 1, all else 0; next state LOADUSE; exactly one bubble per hazard, since the bubble clears lu next cycle.
REQ-022 none: all stall/bubble outputs 0; next state RUN.
REQ-023 stall/bubble outputs SHALL be combinational from current inputs (zero-latency); ctrl_o_state SHALL lag the cause by one cycle.
REQ-024 A redirect arriving under memstall or mdu_busy SHALL be honoured on the first cycle that cause deasserts (E is held, so redirect persists).
REQ-025 Each cycle, the counter of the selected cause (mem, ex, lu, flush=redirect) SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-026 ctrl_i_cnt_clr SHALL zero all counters on the next edge; clr wins over a same-cycle increment.
REQ-027 stall_X and bubble_X SHALL never be asserted together for the same register.

Reset
REQ-028 rst low SHALL immediately (asynchronously) force state = RUN and all counters = 0.
REQ-029 While rst low, all stall and bubble outputs SHALL be 0.
REQ-030 rst deasserting mid-stall SHALL resume with state RUN; causes re-evaluated from inputs on the first cycle.

Verification
REQ-031 Load-use: regE rd=5, is_load=1, reg_wen=1; decode rs2=5, rs2_used=1 -> one cycle stall_F=stall_D=bubble_E=1, then state=1, cnt_lu=1; rd=0 same case -> no stall.
REQ-032 Cache miss: dcache_req=1, ready=0 for 3 cycles -> stall_F/D/E/M and bubble_W high 3 cycles, cnt_mem=3, ready cycle all 0.
REQ-033 Miss + redirect: redirect=1 during 2-cycle miss -> no bubble_D/E until ready=1, then bubble_D=bubble_E=1 one cycle, cnt_flush=1.
REQ-034 MDU: mdu_busy=1 for 10 cycles with lu true -> stall_F/D/E + bubble_M 10 cycles, cnt_ex=10, cnt_lu unchanged.
REQ-035 Saturation/clear: CNT_W=4, 20 miss cycles -> cnt_mem=15; cnt_clr with miss -> cnt_mem=0 next edge.
REQ-036 Async reset: rst low mid-miss between edges -> outputs 0, state 0, counters 0 without a clock edge.
